// File: rtl/spiflash_responder.sv
// SPI/QSPI flash device model: decodes 0x03/0xEB/0xAB/0xB9/0xFF
// and serves read data from a 1-cycle-latency byte read port.
//
// Ports:
//   clk, reset       system clock, sync active-high reset
//   flash_csb        chip select (active low)
//   flash_clk        SPI clock, mode 0
//   io_di[3:0]       pad inputs io3..io0
//   io_do/io_oe      registered pad outputs / enables
//   mem_rd/mem_addr  one-cycle read strobe and byte address
//   mem_rdata        read data, valid the cycle after mem_rd
//   powered_down     deep power-down status
//   cont_mode        continuous-read (0xEB mode) status
module spiflash_responder #(
  parameter int ADDR_W      = 24,
  parameter int DUMMY       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic [3:0]        io_di,
  output logic [3:0]        io_do,
  output logic [3:0]        io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              powered_down,
  output logic              cont_mode
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_S,
    S_ADDR_Q,
    S_MODE,
    S_DUMMY,
    S_DATA_S,
    S_DATA_Q,
    S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0]      r_csb_sync;
  logic [SYNC_STAGES-1:0]      r_sck_sync;
  logic [SYNC_STAGES-1:0][3:0] r_di_sync;
  logic                        r_csb_d;
  logic                        r_sck_d;

  logic w_csb_s;
  logic w_sck_s;
  logic [3:0] w_di_s;
  logic w_csb_fall;
  logic w_rise;
  logic w_fall;

  logic [4:0]        r_cnt;
  logic [22:0]       r_sh;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic              r_rd_d;
  logic [7:0]        r_nbuf;
  logic [7:0]        r_cur;
  logic [3:0]        r_do;
  logic [3:0]        r_oe;
  logic              r_pd;
  logic              r_cont;

  logic [23:0] w_sh_s;
  logic [23:0] w_sh_q;
  logic [23:0] w_addr_full;
  logic [7:0]  w_op;
  logic [7:0]  w_nbyte;

  logic w_fetch;
  logic w_pd_set;
  logic w_pd_clr;
  logic w_cm_clr;
  logic w_cm_upd;
  logic w_shift_s;
  logic w_shift_q;
  logic w_cnt_inc;
  logic w_drive_s;
  logic w_drive_q;
  logic w_data_nxt;

  // Synchronizers. csb chain resets low so a csb already low after
  // reset produces no fall: the host must raise and drop it again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csb_sync <= '0;
      r_sck_sync <= '0;
      r_di_sync  <= '0;
      r_csb_d    <= 1'b0;
      r_sck_d    <= 1'b0;
    end else begin
      r_csb_sync[0] <= flash_csb;
      r_sck_sync[0] <= flash_clk;
      r_di_sync[0]  <= io_di;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_csb_sync[i] <= r_csb_sync[i-1];
        r_sck_sync[i] <= r_sck_sync[i-1];
        r_di_sync[i]  <= r_di_sync[i-1];
      end
      r_csb_d <= w_csb_s;
      r_sck_d <= w_sck_s;
    end
  end

  assign w_csb_s    = r_csb_sync[SYNC_STAGES-1];
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_di_s     = r_di_sync[SYNC_STAGES-1];
  assign w_csb_fall = ~w_csb_s & r_csb_d;
  assign w_rise     = w_sck_s & ~r_sck_d;
  assign w_fall     = ~w_sck_s & r_sck_d;

  assign w_sh_s = {r_sh, w_di_s[0]};
  assign w_sh_q = {r_sh[19:0], w_di_s};
  assign w_op   = w_sh_s[7:0];

  assign w_addr_full = (r_state == S_ADDR_Q) ? w_sh_q : w_sh_s;

  // Bypass covers a fall that arrives the same cycle the data does.
  assign w_nbyte = r_rd_d ? mem_rdata : r_nbuf;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_fetch   = 1'b0;
    w_pd_set  = 1'b0;
    w_pd_clr  = 1'b0;
    w_cm_clr  = 1'b0;
    w_cm_upd  = 1'b0;
    w_shift_s = 1'b0;
    w_shift_q = 1'b0;
    w_cnt_inc = 1'b0;
    w_drive_s = 1'b0;
    w_drive_q = 1'b0;
    if (w_csb_s) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_csb_fall)
            w_next = r_cont ? S_ADDR_Q : S_CMD;
        end
        S_CMD: begin
          if (w_rise) begin
            w_shift_s = 1'b1;
            w_cnt_inc = 1'b1;
            if (r_cnt == 5'd7) begin
              w_next = S_IGNORE;
              if (r_pd) begin
                w_pd_clr = (w_op == 8'hAB);
              end else begin
                case (w_op)
                  8'h03:   w_next   = S_ADDR_S;
                  8'hEB:   w_next   = S_ADDR_Q;
                  8'hAB:   w_pd_clr = 1'b1;
                  8'hB9:   w_pd_set = 1'b1;
                  8'hFF:   w_cm_clr = 1'b1;
                  default: w_next   = S_IGNORE;
                endcase
              end
            end
          end
        end
        S_ADDR_S: begin
          if (w_rise) begin
            w_shift_s = 1'b1;
            w_cnt_inc = 1'b1;
            if (r_cnt == 5'd23) begin
              w_fetch = 1'b1;
              w_next  = S_DATA_S;
            end
          end
        end
        S_ADDR_Q: begin
          if (w_rise) begin
            w_shift_q = 1'b1;
            w_cnt_inc = 1'b1;
            if (r_cnt == 5'd5) begin
              w_fetch = 1'b1;
              w_next  = S_MODE;
            end
          end
        end
        S_MODE: begin
          if (w_rise) begin
            w_shift_q = 1'b1;
            w_cnt_inc = 1'b1;
            if (r_cnt == 5'd1) begin
              w_cm_upd = 1'b1;
              w_next = (DUMMY == 0) ? S_DATA_Q : S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (w_rise) begin
            w_cnt_inc = 1'b1;
            if (r_cnt == 5'(DUMMY - 1))
              w_next = S_DATA_Q;
          end
        end
        S_DATA_S: w_drive_s = w_fall;
        S_DATA_Q: w_drive_q = w_fall;
        S_IGNORE: w_next = S_IGNORE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  assign w_data_nxt = (w_next == S_DATA_S) ||
                      (w_next == S_DATA_Q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sh   <= '0;
      r_addr <= '0;
      r_rd   <= 1'b0;
      r_rd_d <= 1'b0;
      r_nbuf <= '0;
      r_cur  <= '0;
      r_do   <= '0;
      r_oe   <= '0;
      r_pd   <= 1'b0;
      r_cont <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_rd_d <= r_rd;
      if (r_rd_d)
        r_nbuf <= mem_rdata;

      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_cnt_inc || w_drive_s || w_drive_q)
        r_cnt <= r_cnt + 5'd1;

      if (w_shift_s) r_sh <= w_sh_s[22:0];
      if (w_shift_q) r_sh <= w_sh_q[22:0];

      if (w_pd_set) r_pd <= 1'b1;
      if (w_pd_clr) r_pd <= 1'b0;
      if (w_cm_clr) r_cont <= 1'b0;
      // Mode bits [5:4] sit in the low half of the first nibble.
      if (w_cm_upd) r_cont <= (r_sh[1:0] == 2'b10);

      if (w_fetch) begin
        r_addr <= w_addr_full[ADDR_W-1:0];
        r_rd   <= 1'b1;
      end

      if (!w_data_nxt) begin
        r_oe <= '0;
        r_do <= '0;
      end else if (w_drive_s) begin
        r_oe <= 4'b0010;
        if (r_cnt[2:0] == 3'd0) begin
          r_do   <= {2'b00, w_nbyte[7], 1'b0};
          r_cur  <= {w_nbyte[6:0], 1'b0};
          r_addr <= r_addr + ADDR_W'(1);
          r_rd   <= 1'b1;
        end else begin
          r_do  <= {2'b00, r_cur[7], 1'b0};
          r_cur <= {r_cur[6:0], 1'b0};
        end
      end else if (w_drive_q) begin
        r_oe <= 4'b1111;
        if (r_cnt[0] == 1'b0) begin
          r_do   <= w_nbyte[7:4];
          r_cur  <= {w_nbyte[3:0], 4'h0};
          r_addr <= r_addr + ADDR_W'(1);
          r_rd   <= 1'b1;
        end else begin
          r_do <= r_cur[7:4];
        end
      end
    end
  end

  assign io_do        = r_do;
  assign io_oe        = r_oe;
  assign mem_rd       = r_rd;
  assign mem_addr     = r_addr;
  assign powered_down = r_pd;
  assign cont_mode    = r_cont;

endmodule

// File: tb/tb_spiflash_responder.sv
// Bench for spiflash_responder: directed SPI/QSPI transactions,
// expected bytes queued from a memory model and popped on readout.
module tb_spiflash_responder;

  localparam int HALF  = 4;
  localparam int DUMMY = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       csb = 1'b1;
  logic       csb8 = 1'b1;
  logic       sck = 1'b0;
  logic [3:0] di = 4'h0;

  logic [3:0]  io_do, io_oe, io_do8, io_oe8;
  logic        mem_rd, mem_rd8;
  logic [23:0] mem_addr;
  logic [7:0]  mem_addr8;
  logic [7:0]  rdata, rdata8;
  logic        pd, cm, pd8, cm8;

  logic [7:0]  mem  [0:1023];
  logic [7:0]  mem8 [0:255];
  logic [7:0]  exp_q [$];
  logic [23:0] rd_q [$];
  int          rd_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  bit         sel8 = 1'b0;
  logic [3:0] oe_seen;
  logic [3:0] oe_last;
  logic [3:0] oe_pre;

  always #5 clk = ~clk;

  spiflash_responder #(.ADDR_W(24), .DUMMY(DUMMY)) dut (
    .clk(clk), .reset(reset),
    .flash_csb(csb), .flash_clk(sck),
    .io_di(di), .io_do(io_do), .io_oe(io_oe),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(rdata),
    .powered_down(pd), .cont_mode(cm)
  );

  spiflash_responder #(.ADDR_W(8), .DUMMY(DUMMY)) dut8 (
    .clk(clk), .reset(reset),
    .flash_csb(csb8), .flash_clk(sck),
    .io_di(di), .io_do(io_do8), .io_oe(io_oe8),
    .mem_rd(mem_rd8), .mem_addr(mem_addr8),
    .mem_rdata(rdata8),
    .powered_down(pd8), .cont_mode(cm8)
  );

  always @(posedge clk) begin
    if (mem_rd) begin
      rdata <= mem[mem_addr[9:0]];
      rd_q.push_back(mem_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_rd8)
      rdata8 <= mem8[mem_addr8];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_cycle(input logic [3:0] d,
                           output logic [3:0] q);
    di = d;
    tick(HALF);
    q = sel8 ? io_do8 : io_do;
    oe_last = sel8 ? io_oe8 : io_oe;
    oe_seen = oe_seen | oe_last;
    sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--)
      sck_cycle({3'b000, b[i]}, q);
  endtask

  task automatic send_q(input logic [3:0] n);
    logic [3:0] q;
    sck_cycle(n, q);
  endtask

  task automatic read_s(output logic [7:0] b);
    logic [3:0] q;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(4'h0, q);
      b = {b[6:0], q[1]};
    end
  endtask

  task automatic read_q(output logic [7:0] b);
    logic [3:0] hi, lo;
    sck_cycle(4'h0, hi);
    sck_cycle(4'h0, lo);
    b = {hi, lo};
  endtask

  task automatic push_exp(input logic [23:0] a, input int n);
    logic [23:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 24'(i);
      exp_q.push_back(sel8 ? mem8[ai[7:0]] : mem[ai[9:0]]);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] got);
    logic [7:0] e;
    check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  task automatic cs_begin();
    if (sel8) csb8 = 1'b0;
    else      csb  = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    csb  = 1'b1;
    csb8 = 1'b1;
    tick(8);
  endtask

  task automatic spi_read(input logic [23:0] a, input int n,
                          input string tag);
    logic [7:0] b;
    oe_seen = '0;
    cs_begin();
    send_s(8'h03);
    send_s(a[23:16]);
    send_s(a[15:8]);
    send_s(a[7:0]);
    oe_pre = oe_seen;
    push_exp(a, n);
    for (int i = 0; i < n; i++) begin
      read_s(b);
      pop_check(tag, b);
    end
    cs_end();
  endtask

  task automatic quad_read(input logic [23:0] a,
                           input logic [7:0] mode,
                           input int n, input bit use_cmd,
                           input string tag);
    logic [7:0] b;
    cs_begin();
    if (use_cmd) send_s(8'hEB);
    for (int i = 5; i >= 0; i--) send_q(a[i*4 +: 4]);
    send_q(mode[7:4]);
    send_q(mode[3:0]);
    for (int i = 0; i < DUMMY; i++) send_q(4'h0);
    push_exp(a, n);
    for (int i = 0; i < n; i++) begin
      read_q(b);
      pop_check(tag, b);
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] q;
    int n0;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 3 + 5);
    for (int i = 0; i < 256; i++)  mem8[i] = 8'(i ^ 8'h3C);
    mem[16'h010] = 8'h11; mem[16'h011] = 8'h22;
    mem[16'h012] = 8'h33; mem[16'h013] = 8'h44;
    mem[16'h100] = 8'h12; mem[16'h101] = 8'h34;
    mem[16'h102] = 8'h56; mem[16'h103] = 8'h78;
    mem[16'h200] = 8'hA1; mem[16'h201] = 8'hB2;
    mem[16'h202] = 8'hC3; mem[16'h203] = 8'hD4;
    mem8[255] = 8'hA5;
    mem8[0]   = 8'h5A;

    tick(4);
    reset = 1'b0;
    tick(2);
    check("rst_oe", io_oe, 4'h0);
    check("rst_do", io_do, 4'h0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_addr", mem_addr, 24'h0);
    check("rst_pd", pd, 1'b0);
    check("rst_cm", cm, 1'b0);

    // single serial read
    rd_q.delete();
    spi_read(24'h000010, 4, "sread");
    check("sread_oe_addr", oe_pre, 4'h0);
    check("sread_oe_data", oe_last, 4'b0010);
    check("sread_oe_end", io_oe, 4'h0);
    check("sread_nrd", rd_q.size(), 5);
    for (int i = 0; i < 5 && i < rd_q.size(); i++)
      check("sread_maddr", rd_q[i], 24'h10 + 24'(i));

    // quad read, mode 0x00
    quad_read(24'h000100, 8'h00, 4, 1'b1, "qread");
    check("qread_cm", cm, 1'b0);

    // continuous mode entry, opcode-less read, exit
    quad_read(24'h000180, 8'hA0, 2, 1'b1, "cont_in");
    check("cont_set", cm, 1'b1);
    quad_read(24'h000200, 8'hFF, 4, 1'b0, "cont_rd");
    check("cont_clr", cm, 1'b0);
    spi_read(24'h000010, 2, "cont_after");

    // power-down
    cs_begin(); send_s(8'hB9); cs_end();
    check("pd_set", pd, 1'b1);
    n0 = rd_cnt;
    oe_seen = '0;
    cs_begin();
    send_s(8'h03);
    send_s(8'h00); send_s(8'h00); send_s(8'h10);
    for (int i = 0; i < 16; i++) sck_cycle(4'h0, q);
    cs_end();
    check("pd_oe", oe_seen, 4'h0);
    check("pd_nrd", rd_cnt, n0);
    cs_begin(); send_s(8'hAB); cs_end();
    check("pd_clr", pd, 1'b0);
    spi_read(24'h000012, 2, "pd_after");

    // address wrap on the 8-bit instance
    sel8 = 1'b1;
    spi_read(24'h0000FF, 2, "wrap");
    sel8 = 1'b0;

    // abort mid-byte
    cs_begin();
    send_s(8'h03);
    send_s(8'h00); send_s(8'h00); send_s(8'h11);
    push_exp(24'h000011, 1);
    read_s(b);
    pop_check("abort_b0", b);
    for (int i = 0; i < 3; i++) sck_cycle(4'h0, q);
    check("abort_pre", io_oe, 4'b0010);
    csb = 1'b1;
    tick(4);
    check("abort_oe", io_oe, 4'h0);
    tick(8);
    spi_read(24'h000020, 2, "post_abort");

    // reset during quad data
    cs_begin();
    send_s(8'hEB);
    for (int i = 5; i >= 0; i--) send_q(4'(24'h000100 >> (i*4)));
    send_q(4'hA);
    send_q(4'h0);
    for (int i = 0; i < DUMMY; i++) send_q(4'h0);
    push_exp(24'h000100, 1);
    read_q(b);
    pop_check("rq_b0", b);
    check("rq_cm", cm, 1'b1);
    sck_cycle(4'h0, q);
    check("rq_oe", io_oe, 4'hF);
    reset = 1'b1;
    tick(1);
    check("rq_rst_oe", io_oe, 4'h0);
    check("rq_rst_do", io_do, 4'h0);
    check("rq_rst_rd", mem_rd, 1'b0);
    check("rq_rst_addr", mem_addr, 24'h0);
    check("rq_rst_pd", pd, 1'b0);
    check("rq_rst_cm", cm, 1'b0);
    reset = 1'b0;
    cs_end();
    spi_read(24'h000013, 1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
